aes128_encrypt_iter: RTL and testbench
======================================

# aes128_encrypt_iter

Iterative AES-128 encryption core: one cipher round per clock, with on-the-fly key expansion and valid/ready handshakes on the input and output sides. It is the encrypt-direction counterpart of the combinational decrypt datapath. It sits behind the Nios V CSR/avalon adapter and produces ciphertext that the decrypt core inverts bit-exactly. Its area is roughly one round of logic, compared with the ten rounds of the fully unrolled datapath.

## Interface
- key_length, 128: key size in bits. Only 128 is supported; elaboration fails for any other value.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plain_txt/key valid.
- in_ready  out  1  core can accept a block.
- plain_txt  in  [0:127]  plaintext block.
- key  in  [0:127]  cipher key.
- out_valid  out  1  cipher_txt valid.
- out_ready  in  1  downstream accepts cipher_txt.
- cipher_txt  out  [0:127]  ciphertext block, registered.
- busy  out  1  high in ROUND or DONE.

## Operation
- Byte order follows FIPS-197. Bit 0 is the MSB. Byte n = bits [8n:8n+7]. Each column is one 32-bit word, so bytes 0..3 form column 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: state_reg <= plain_txt ^ key (round-0 AddRoundKey), rk_reg <= key, rcon <= 8'h01, rnd <= 1, go to ROUND.
  - plain_txt and key are sampled only at this handshake. Later changes on these inputs are ignored.
- ROUND, once per cycle:
  - nk = next round key from rk_reg. Compute w = SubWord(RotWord(rk_reg[96:127])) ^ {rcon,24'h0}. Then nk word0 = rk word0 ^ w, and each word i = rk word i ^ nk word i-1.
  - If rnd < 10: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ nk.
  - If rnd == 10: state_reg <= ShiftRows(SubBytes(state_reg)) ^ nk, cipher_txt <= the same value, out_valid <= 1, go to DONE.
  - Every cycle: rk_reg <= nk, rcon <= xtime(rcon), rnd <= rnd + 1.
  - rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - rnd is a 4-bit counter with range 1..10. It never wraps.
- DONE:
  - cipher_txt and out_valid are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE. cipher_txt keeps its last value.
- in_ready = (state == IDLE) & reset_n. in_valid is ignored outside IDLE, so there is no queueing.
- S-box: forward AES S-box, 16 instances for SubBytes plus 4 for SubWord, all combinational.

## Timing
- Reset (reset_n low), asynchronous:
  - state = IDLE, out_valid = 0, cipher_txt = 0, busy = 0, in_ready = 0 while reset_n is low.
  - rk_reg, state_reg, rnd and rcon are cleared.
- Reset asserted mid-operation aborts the block. No output is produced. The core returns to IDLE with in_ready = 1 on the first cycle after reset_n rises.
- Latency: accept at edge k, then rounds 1..10 at edges k+1..k+10. out_valid is high after edge k+10, so latency is 10 cycles.
- Release: with out_ready high, DONE->IDLE happens at edge k+11. The earliest next accept is edge k+12, giving 12 cycles per block at peak throughput.
- out_ready high before out_valid has no effect.
- No combinational path exists from any input to out_valid or cipher_txt. in_ready depends only on state and reset_n.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready = 1 -> cipher_txt 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly 10 cycles after accept and lasts 1 cycle.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready held low 5 cycles after out_valid -> 3925841d02dc09fbdc118597196a0b32 held stable. busy = 1 and in_ready = 0 throughout.
- Back-to-back: in_valid held high, block A = all-zero key/pt, block B = C.1 vector presented once A is accepted -> in_ready low for 11 cycles. B is accepted at edge k+12. Outputs are 66e94bd4ef8a2c3b884cfa59ca342b2e then 69c4e0d86a7b0430d8cdb78070b4c55a.
- Input hold-off: after accepting the C.1 vector, drive random plain_txt/key every cycle -> result is still 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reset mid-round: assert reset_n low for 2 cycles during round 5 -> out_valid never rises, and all outputs read 0 while reset is held. A fresh App. B block afterwards yields 3925841d02dc09fbdc118597196a0b32 with 10-cycle latency.
- Random regression: 1000 random key/pt pairs with random out_ready backpressure -> each cipher_txt matches the reference AES-128 model, and decrypting it with the decrypt core returns the plaintext.

Source files
------------

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Latency 10 cycles accept-to-out_valid; result held in DONE until out_ready, in_ready low while busy.
module aes128_encrypt_iter #(
    parameter int key_length = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plain_txt,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] cipher_txt,
    output logic         busy
);

    generate
        if (key_length != 128) begin : g_bad_key_length
            $error("aes128_encrypt_iter supports key_length = 128 only");
        end
    endgenerate

    // Forward S-box, row-major: entry b lives at bits [8b:8b+7].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
        return r;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
                r[8*(4*c+q) +: 8] = s[8*(4*((c+q)%4)+q) +: 8];
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c    +: 8];
            a1 = s[32*c+8  +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            r[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [0:127] data_q, data_d;
    logic [0:127] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] cipher_q, cipher_d;
    logic         out_valid_q, out_valid_d;

    logic [0:127] sr, mc, nk;
    logic [0:31]  rot_w, g_w;

    assign in_ready   = (fsm_q == IDLE) & reset_n;
    assign busy       = (fsm_q != IDLE);
    assign out_valid  = out_valid_q;
    assign cipher_txt = cipher_q;

    always_comb begin
        sr    = shift_rows(sub_bytes(data_q));
        mc    = mix_columns(sr);
        rot_w = {rk_q[104:127], rk_q[96:103]};
        g_w   = {sbox(rot_w[0:7]) ^ rcon_q, sbox(rot_w[8:15]),
                 sbox(rot_w[16:23]), sbox(rot_w[24:31])};
        nk[0:31]   = rk_q[0:31]   ^ g_w;
        nk[32:63]  = rk_q[32:63]  ^ nk[0:31];
        nk[64:95]  = rk_q[64:95]  ^ nk[32:63];
        nk[96:127] = rk_q[96:127] ^ nk[64:95];
    end

    always_comb begin
        fsm_d       = fsm_q;
        data_d      = data_q;
        rk_d        = rk_q;
        rcon_d      = rcon_q;
        rnd_d       = rnd_q;
        cipher_d    = cipher_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d = plain_txt ^ key;
                    rk_d   = key;
                    rcon_d = 8'h01;
                    rnd_d  = 4'd1;
                    fsm_d  = ROUND;
                end
            end
            ROUND: begin
                rk_d   = nk;
                rcon_d = xtime(rcon_q);
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    data_d      = sr ^ nk;
                    cipher_d    = sr ^ nk;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    data_d = mc ^ nk;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            data_q      <= '0;
            rk_q        <= '0;
            rcon_q      <= '0;
            rnd_q       <= '0;
            cipher_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            rk_q        <= rk_d;
            rcon_q      <= rcon_d;
            rnd_q       <= rnd_d;
            cipher_q    <= cipher_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: FIPS-197 vectors, handshake timing, reset abort and a random regression
// against a byte-array AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes128_encrypt_iter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] plain_txt = '0;
    logic [0:127] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] cipher_txt;
    logic         busy;

    int checks = 0;
    int failures = 0;

    localparam logic [0:127] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] C_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_encrypt_iter #(.key_length(128)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plain_txt  (plain_txt),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cipher_txt (cipher_txt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [0:127] aes_ref(input logic [0:127] k, input logic [0:127] p);
        logic [7:0]   rk [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x;
        logic [0:127] res;
        rc = 8'h01;
        for (int n = 0; n < 16; n++) rk[n] = k[8*n +: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                x      = tmp[0];
                tmp[0] = sb_tab[tmp[1]] ^ rc;
                tmp[1] = sb_tab[tmp[2]];
                tmp[2] = sb_tab[tmp[3]];
                tmp[3] = sb_tab[x];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tmp[j];
        end
        for (int n = 0; n < 16; n++) s[n] = p[8*n +: 8] ^ rk[n];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = sb_tab[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[16*r+n];
        end
        for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input logic [0:127] k, input logic [0:127] p);
        int n = 0;
        plain_txt = p;
        key       = k;
        in_valid  = 1'b1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chk_eq("send_ready_seen", 128'(n < 40), 128'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int           lat, lowcnt, hi, n;
        logic [0:127] rk, rp, expv;
        logic [0:127] outs [$];

        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

        // Reset
        #2 reset_n = 1'b0;
        #1;
        chk_eq("rst_in_ready", in_ready, 0);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_cipher", cipher_txt, 0);
        chk_eq("rst_busy", busy, 0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk_eq("post_rst_in_ready", in_ready, 1);
        step();

        // Model sanity against the published vectors
        chk_eq("model_c1", aes_ref(K_C1, P_C1), C_C1);
        chk_eq("model_b", aes_ref(K_B, P_B), C_B);

        // FIPS-197 C.1 with out_ready high
        out_ready = 1'b1;
        send(K_C1, P_C1);
        chk_eq("c1_busy", busy, 1);
        chk_eq("c1_in_ready_low", in_ready, 0);
        wait_out(lat);
        chk_eq("c1_latency", lat, 10);
        chk_eq("c1_cipher", cipher_txt, C_C1);
        step();
        chk_eq("c1_valid_one_cycle", out_valid, 0);
        chk_eq("c1_in_ready_back", in_ready, 1);
        chk_eq("c1_cipher_kept", cipher_txt, C_C1);

        // App. B with 5 cycles of backpressure
        out_ready = 1'b0;
        send(K_B, P_B);
        wait_out(lat);
        chk_eq("b_latency", lat, 10);
        chk_eq("b_cipher", cipher_txt, C_B);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_eq("b_hold_valid", out_valid, 1);
            chk_eq("b_hold_cipher", cipher_txt, C_B);
            chk_eq("b_hold_busy", busy, 1);
            chk_eq("b_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk_eq("b_release_valid", out_valid, 0);
        chk_eq("b_release_in_ready", in_ready, 1);
        chk_eq("b_release_busy", busy, 0);

        // Back-to-back with in_valid held high
        plain_txt = '0;
        key       = '0;
        in_valid  = 1'b1;
        step();
        plain_txt = P_C1;
        key       = K_C1;
        lowcnt    = 0;
        while (!in_ready && lowcnt < 40) begin
            if (out_valid) outs.push_back(cipher_txt);
            lowcnt++;
            step();
        end
        chk_eq("b2b_in_ready_low_cycles", lowcnt, 11);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk_eq("b2b_latency_b", lat, 10);
        if (out_valid) outs.push_back(cipher_txt);
        chk_eq("b2b_out_count", outs.size(), 2);
        if (outs.size() == 2) begin
            chk_eq("b2b_out_a", outs[0], C_ZERO);
            chk_eq("b2b_out_b", outs[1], C_C1);
        end
        step();

        // Inputs change every cycle after the accept
        send(K_C1, P_C1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            plain_txt = {$urandom(), $urandom(), $urandom(), $urandom()};
            key       = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            lat++;
        end
        chk_eq("holdoff_latency", lat, 10);
        chk_eq("holdoff_cipher", cipher_txt, C_C1);
        step();

        // Reset during round 5
        send(K_B, P_B);
        for (int i = 0; i < 4; i++) step();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_eq("midrst_in_ready", in_ready, 0);
            chk_eq("midrst_out_valid", out_valid, 0);
            chk_eq("midrst_cipher", cipher_txt, 0);
            chk_eq("midrst_busy", busy, 0);
            step();
        end
        reset_n = 1'b1;
        #1;
        chk_eq("midrst_in_ready_after", in_ready, 1);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) hi++;
        end
        chk_eq("midrst_no_output", hi, 0);
        send(K_B, P_B);
        wait_out(lat);
        chk_eq("midrst_fresh_latency", lat, 10);
        chk_eq("midrst_fresh_cipher", cipher_txt, C_B);
        step();

        // Random regression with random backpressure
        for (int b = 0; b < 1000; b++) begin
            rk   = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp   = {$urandom(), $urandom(), $urandom(), $urandom()};
            expv = aes_ref(rk, rp);
            send(rk, rp);
            lat = 0;
            while (!out_valid && lat < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                lat++;
            end
            chk_eq("rand_latency", lat, 10);
            chk_eq("rand_cipher", cipher_txt, expv);
            n = 0;
            while (out_valid && n < 64) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                n++;
                if (out_valid) chk_eq("rand_hold_cipher", cipher_txt, expv);
            end
            chk_eq("rand_released", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
